// File: rtl/multicycle_alu.sv
// ============================================================================
// Module      : multicycle_alu
// Description : Handshaked ALU; single-cycle ops plus an optional iterative
//               restoring divider for MOD/DIV (enabled by MULTICYCLE_ALU_DIV_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_alu #(
    parameter int WIDTH              = 8,
    parameter int DIV_CYCLES_PER_BIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             div_by_zero,
    output logic             illegal_op
);

    localparam logic [3:0] c_OP_ADD = 4'h0;
    localparam logic [3:0] c_OP_SUB = 4'h1;
    localparam logic [3:0] c_OP_AND = 4'h2;
    localparam logic [3:0] c_OP_OR  = 4'h3;
    localparam logic [3:0] c_OP_XOR = 4'h4;
    localparam logic [3:0] c_OP_SHL = 4'h5;
    localparam logic [3:0] c_OP_SHR = 4'h6;
    localparam logic [3:0] c_OP_SQR = 4'h8;
    localparam logic [3:0] c_OP_PAR = 4'h9;
    localparam logic [3:0] c_OP_NOT = 4'hA;
    localparam logic [3:0] c_OP_SRA = 4'hC;

`ifdef MULTICYCLE_ALU_DIV_EN
    localparam logic [3:0] c_OP_MOD = 4'h7;
    localparam logic [3:0] c_OP_DIV = 4'hB;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DONE = 2'd2
    } state_t;
`endif

    state_t           r_state;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_carry;
    logic             r_overflow;
    logic             r_div_by_zero;
    logic             r_illegal_op;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_res;
    logic             w_zero;
    logic             w_carry;
    logic             w_ovf;
    logic             w_dbz;
    logic             w_ill;
    logic             w_go_calc;

    always_comb begin
        w_sum     = {1'b0, a} + {1'b0, b};
        w_diff    = {1'b0, a} - {1'b0, b};
        w_res     = '0;
        w_carry   = 1'b0;
        w_ovf     = 1'b0;
        w_dbz     = 1'b0;
        w_ill     = 1'b0;
        w_go_calc = 1'b0;
        case (op)
            c_OP_ADD: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            c_OP_SUB: begin
                w_res   = w_diff[WIDTH-1:0];
                w_carry = w_diff[WIDTH];
                w_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            c_OP_AND: w_res = a & b;
            c_OP_OR:  w_res = a | b;
            c_OP_XOR: w_res = a ^ b;
            c_OP_SHL: begin
                w_res   = {a[WIDTH-2:0], 1'b0};
                w_carry = a[WIDTH-1];
            end
            c_OP_SHR: begin
                w_res   = {1'b0, a[WIDTH-1:1]};
                w_carry = a[0];
            end
            c_OP_SQR: w_res = a * a;
            c_OP_PAR: w_res = {{(WIDTH-1){1'b0}}, ^a};
            c_OP_NOT: w_res = ~a;
            c_OP_SRA: begin
                w_res   = {a[WIDTH-1], a[WIDTH-1:1]};
                w_carry = a[0];
            end
`ifdef MULTICYCLE_ALU_DIV_EN
            c_OP_MOD, c_OP_DIV: begin
                if (b == '0) begin
                    w_res = '1;
                    w_dbz = 1'b1;
                end else begin
                    w_go_calc = 1'b1;
                end
            end
`endif
            default: w_ill = 1'b1;
        endcase
        w_zero = (w_res == '0) && !w_ill;
    end

`ifdef MULTICYCLE_ALU_DIV_EN
    localparam int c_DIV_STEPS = WIDTH * DIV_CYCLES_PER_BIT;
    localparam int c_CNT_W     = $clog2(c_DIV_STEPS + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_DIV_STEPS - 1);

    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quot;
    logic [WIDTH-1:0]   r_dvsr;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_is_mod;

    logic [WIDTH:0]     w_trial;
    logic               w_fits;
    logic               w_step;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [WIDTH-1:0]   w_quot_nxt;
    logic [WIDTH-1:0]   w_div_res;

    // The dividend is shifted out of r_quot MSB-first while quotient bits enter at the LSB.
    always_comb begin
        w_trial    = {r_rem, r_quot[WIDTH-1]} - {1'b0, r_dvsr};
        w_fits     = ~w_trial[WIDTH];
        w_rem_nxt  = w_fits ? w_trial[WIDTH-1:0] : {r_rem[WIDTH-2:0], r_quot[WIDTH-1]};
        w_quot_nxt = {r_quot[WIDTH-2:0], w_fits};
        w_step     = (DIV_CYCLES_PER_BIT == 1) || r_cnt[0];
        w_div_res  = r_is_mod ? w_rem_nxt : w_quot_nxt;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_result      <= '0;
            r_zero        <= 1'b0;
            r_carry       <= 1'b0;
            r_overflow    <= 1'b0;
            r_div_by_zero <= 1'b0;
            r_illegal_op  <= 1'b0;
`ifdef MULTICYCLE_ALU_DIV_EN
            r_rem         <= '0;
            r_quot        <= '0;
            r_dvsr        <= '0;
            r_cnt         <= '0;
            r_is_mod      <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
`ifdef MULTICYCLE_ALU_DIV_EN
                        if (w_go_calc) begin
                            r_rem    <= '0;
                            r_quot   <= a;
                            r_dvsr   <= b;
                            r_cnt    <= '0;
                            r_is_mod <= (op == c_OP_MOD);
                            r_state  <= S_CALC;
                        end else
`endif
                        begin
                            r_result      <= w_res;
                            r_zero        <= w_zero;
                            r_carry       <= w_carry;
                            r_overflow    <= w_ovf;
                            r_div_by_zero <= w_dbz;
                            r_illegal_op  <= w_ill;
                            r_state       <= S_DONE;
                        end
                    end
                end
`ifdef MULTICYCLE_ALU_DIV_EN
                S_CALC: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_step) begin
                        r_rem  <= w_rem_nxt;
                        r_quot <= w_quot_nxt;
                    end
                    if (r_cnt == c_CNT_LAST) begin
                        r_result      <= w_div_res;
                        r_zero        <= (w_div_res == '0);
                        r_carry       <= 1'b0;
                        r_overflow    <= 1'b0;
                        r_div_by_zero <= 1'b0;
                        r_illegal_op  <= 1'b0;
                        r_state       <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = (r_state == S_DONE);
    assign result      = r_result;
    assign zero        = r_zero;
    assign carry       = r_carry;
    assign overflow    = r_overflow;
    assign div_by_zero = r_div_by_zero;
    assign illegal_op  = r_illegal_op;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_alu.sv
// ============================================================================
// Module      : tb_multicycle_alu
// Description : Self-checking bench for multicycle_alu (WIDTH=8); expectations
//               follow MULTICYCLE_ALU_DIV_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_alu;

    localparam int W = 8;
`ifdef MULTICYCLE_ALU_DIV_EN
    localparam bit c_DIV_EN = 1'b1;
`else
    localparam bit c_DIV_EN = 1'b0;
`endif

    logic         clk       = 1'b0;
    logic         reset     = 1'b1;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b0;
    logic [3:0]   op        = 4'h0;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] result;
    logic         zero;
    logic         carry;
    logic         overflow;
    logic         div_by_zero;
    logic         illegal_op;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    multicycle_alu #(.WIDTH(W), .DIV_CYCLES_PER_BIT(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .op         (op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .carry      (carry),
        .overflow   (overflow),
        .div_by_zero(div_by_zero),
        .illegal_op (illegal_op)
    );

    typedef struct packed {
        logic [7:0] res;
        logic [4:0] fl;   // {zero, carry, overflow, div_by_zero, illegal_op}
        logic [7:0] lat;
    } exp_t;

    function automatic exp_t ref_model(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
        exp_t e;
        int   ux, uy, sx, sy, s, r;
        bit   c, v, dz, ill;
        ux = x; uy = y; sx = $signed(x); sy = $signed(y);
        r = 0; c = 0; v = 0; dz = 0; ill = 0;
        e.lat = 8'd1;
        case (o)
            4'd0: begin s = ux + uy; r = s % 256; c = (s > 255); v = (sx + sy > 127) || (sx + sy < -128); end
            4'd1: begin s = ux - uy; r = (s + 256) % 256; c = (ux < uy); v = (sx - sy > 127) || (sx - sy < -128); end
            4'd2: r = int'(x & y);
            4'd3: r = int'(x | y);
            4'd4: r = int'(x ^ y);
            4'd5: begin r = (ux * 2) % 256; c = (ux >= 128); end
            4'd6: begin r = ux / 2; c = (ux % 2 == 1); end
            4'd7, 4'd11: begin
                if (!c_DIV_EN) ill = 1;
                else if (uy == 0) begin r = 255; dz = 1; end
                else begin
                    r = (o == 4'd7) ? ux % uy : ux / uy;
                    e.lat = 8'(W + 1);
                end
            end
            4'd8:  r = (ux * ux) % 256;
            4'd9:  r = $countones(x) % 2;
            4'd10: r = 255 - ux;
            4'd12: begin r = ux / 2 + ((ux >= 128) ? 128 : 0); c = (ux % 2 == 1); end
            default: ill = 1;
        endcase
        e.res = 8'(r);
        e.fl  = {(r == 0) && !ill, c, v, dz, ill};
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Transaction-level model: idle (0), busy (1), holding a result (2); -1 until first reset.
    exp_t w_ref;
    assign w_ref = ref_model(op, a, b);

    int   m_phase = -1;
    int   m_cnt   = 0;
    exp_t m_exp   = '0;
    bit   m_clean = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_phase <= 0;
            m_clean <= 1'b1;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_exp   <= w_ref;
                    m_clean <= 1'b0;
                    m_cnt   <= int'(w_ref.lat) - 1;
                    m_phase <= (w_ref.lat == 8'd1) ? 2 : 1;
                end
                1: begin
                    m_cnt <= m_cnt - 1;
                    if (m_cnt == 1) m_phase <= 2;
                end
                2: if (out_ready) m_phase <= 0;
                default: m_phase <= m_phase;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_phase >= 0 && !reset) begin
            chk("in_ready", 32'(in_ready), 32'(m_phase == 0));
            chk("out_valid", 32'(out_valid), 32'(m_phase == 2));
            if (m_phase == 2) begin
                chk("result", 32'(result), 32'(m_exp.res));
                chk("flags", 32'({zero, carry, overflow, div_by_zero, illegal_op}), 32'(m_exp.fl));
            end
            if (m_clean) begin
                chk("reset_result", 32'(result), 32'd0);
                chk("reset_flags", 32'({zero, carry, overflow, div_by_zero, illegal_op}), 32'd0);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_op(input string nm, input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] er, input logic [4:0] ef, input int elat, input int hold);
        int n;
        int lat;
        n = 0;
        out_ready = 1'b1;
        while (!in_ready && n < 50) begin step(); n++; end
        out_ready = 1'b0;
        in_valid = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1;
        in_valid = 1'b0; op = 4'($urandom); a = W'($urandom); b = W'($urandom);
        lat = 0;
        while (lat < 40) begin
            step();
            lat++;
            if (out_valid) break;
        end
        chk({nm, "_latency"}, 32'(lat), 32'(elat));
        chk({nm, "_result"}, 32'(result), 32'(er));
        chk({nm, "_flags"}, 32'({zero, carry, overflow, div_by_zero, illegal_op}), 32'(ef));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom); op = 4'($urandom);
            step();
            chk({nm, "_hold_result"}, 32'(result), 32'(er));
            chk({nm, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();

        do_op("add_ff_01", 4'h0, 8'hFF, 8'h01, 8'h00, 5'b11000, 1, 0);
        do_op("sub_80_01", 4'h1, 8'h80, 8'h01, 8'h7F, 5'b00100, 1, 0);
        do_op("sra_81",    4'hC, 8'h81, 8'h00, 8'hC0, 5'b01000, 1, 0);
        do_op("xor_hold",  4'h4, 8'h3C, 8'h0F, 8'h33, 5'b00000, 1, 3);
        do_op("illegal_f", 4'hF, 8'h12, 8'h34, 8'h00, 5'b00001, 1, 0);
        if (c_DIV_EN) begin
            do_op("mod_200_7", 4'h7, 8'd200, 8'd7, 8'd4,  5'b00000, W + 1, 0);
            do_op("div_200_7", 4'hB, 8'd200, 8'd7, 8'd28, 5'b00000, W + 1, 0);
            do_op("div_by_0",  4'hB, 8'h55, 8'h00, 8'hFF, 5'b00010, 1, 0);
        end else begin
            do_op("mod_illegal", 4'h7, 8'd200, 8'd7, 8'h00, 5'b00001, 1, 0);
            do_op("div_illegal", 4'hB, 8'h55, 8'h00, 8'h00, 5'b00001, 1, 0);
        end

        // Reset arrives while a division is in flight.
        out_ready = 1'b1;
        for (int n = 0; n < 50 && !in_ready; n++) step();
        out_ready = 1'b0;
        in_valid = 1'b1; op = 4'hB; a = 8'd200; b = 8'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
        chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_result", 32'(result), 32'd0);
        do_op("add_2_3", 4'h0, 8'd2, 8'd3, 8'd5, 5'b00000, 1, 0);

        for (int i = 0; i < 1500; i++) begin
            step();
            reset     = ($urandom_range(0, 199) == 0);
            in_valid  = ($urandom_range(0, 99) < 60);
            op        = 4'($urandom_range(0, 15));
            a         = W'($urandom);
            b         = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom);
            out_ready = 1'($urandom);
        end
        reset = 1'b0;
        in_valid = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
